// File: rtl/rv32i_types.sv
// Shared types for the data-memory port arbiter.
//   dmem_arb_state_t : arbiter FSM state (IDLE / LD_BUSY / ST_BUSY)
//   dmem_req_t       : one registered memory request (addr, rmask, wmask, wdata)
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_BUSY = 2'd1,
        ST_BUSY = 2'd2
    } dmem_arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares the single data-memory port between the memory-unit load path and
// the store-buffer drain path. One transaction at a time: a grant in IDLE
// registers the request onto dmem_*, which holds until dmem_resp. The
// response is steered back to its owner the same cycle; load responses are
// dropped if a pipeline flush hit while the load was outstanding.
//
// Optional feature macro: DMEM_ARB_STARVE_EN
//   defined   : 4-bit starvation counter forces a store after STARVE_LIMIT
//               consecutive load grants made while a store was waiting.
//   undefined : stores win only when urgent or when no load is pending.
//
// Ports:
//   clk, rst (async, active-low), flush
//   ld_req/ld_addr/ld_rmask  -> ld_ready, ld_resp, ld_rdata
//   st_req/st_urgent/st_addr/st_wmask/st_wdata -> st_ready, st_resp
//   dmem_addr/dmem_rmask/dmem_wmask/dmem_wdata -> memory; dmem_rdata/dmem_resp <- memory
//   busy : a transaction is outstanding
module dmem_port_arbiter
    import rv32i_types::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [3:0]  ld_rmask,
    output logic        ld_ready,
    output logic        ld_resp,
    output logic [31:0] ld_rdata,
    input  logic        st_req,
    input  logic        st_urgent,
    input  logic [31:0] st_addr,
    input  logic [3:0]  st_wmask,
    input  logic [31:0] st_wdata,
    output logic        st_ready,
    output logic        st_resp,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        busy
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
        $error("dmem_port_arbiter: STARVE_LIMIT must be in 1..15");
    end

    dmem_arb_state_t r_state;
    dmem_arb_state_t w_state_next;
    dmem_req_t       r_req;
    logic            r_squash;
    logic            w_grant_ld;
    logic            w_grant_st;
    logic            w_starve;

`ifdef DMEM_ARB_STARVE_EN
    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] r_starve_cnt;

    // Counts loads that jumped ahead of a waiting store; any cycle without
    // a waiting store, or a store grant, restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= 4'h0;
        end else if (!st_req || w_grant_st) begin
            r_starve_cnt <= 4'h0;
        end else if (w_grant_ld) begin
            r_starve_cnt <= r_starve_cnt + 4'h1;
        end
    end

    assign w_starve = st_req && (r_starve_cnt == LP_LIMIT);
`else
    assign w_starve = 1'b0;
`endif

    // Grant decision. Gated by rst so ready stays low while reset is held.
    always_comb begin
        w_grant_ld = 1'b0;
        w_grant_st = 1'b0;
        if (r_state == IDLE && rst) begin
            if (st_urgent && st_req) begin
                w_grant_st = 1'b1;
            end else if (w_starve) begin
                w_grant_st = 1'b1;
            end else if (ld_req && !flush) begin
                w_grant_ld = 1'b1;
            end else if (st_req) begin
                w_grant_st = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ld_ready     = 1'b0;
        st_ready     = 1'b0;
        ld_resp      = 1'b0;
        st_resp      = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                ld_ready = w_grant_ld;
                st_ready = w_grant_st;
                if (w_grant_ld) begin
                    w_state_next = LD_BUSY;
                end else if (w_grant_st) begin
                    w_state_next = ST_BUSY;
                end
            end
            LD_BUSY: begin
                busy    = 1'b1;
                // A flush on the response cycle itself also drops the data.
                ld_resp = dmem_resp && !r_squash && !flush;
                if (dmem_resp) begin
                    w_state_next = IDLE;
                end
            end
            ST_BUSY: begin
                busy    = 1'b1;
                st_resp = dmem_resp;
                if (dmem_resp) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req    <= '0;
            r_squash <= 1'b0;
        end else begin
            if (w_grant_ld) begin
                r_req <= '{addr: ld_addr, rmask: ld_rmask, wmask: 4'h0, wdata: 32'h0};
            end else if (w_grant_st) begin
                r_req <= '{addr: st_addr, rmask: 4'h0, wmask: st_wmask, wdata: st_wdata};
            end else if (r_state != IDLE && dmem_resp) begin
                // Only the masks retire; addr/wdata may linger harmlessly.
                r_req.rmask <= 4'h0;
                r_req.wmask <= 4'h0;
            end

            if (r_state == LD_BUSY) begin
                if (dmem_resp) begin
                    r_squash <= 1'b0;
                end else if (flush) begin
                    r_squash <= 1'b1;
                end
            end else begin
                r_squash <= 1'b0;
            end
        end
    end

    assign dmem_addr  = r_req.addr;
    assign dmem_rmask = r_req.rmask;
    assign dmem_wmask = r_req.wmask;
    assign dmem_wdata = r_req.wdata;
    assign ld_rdata   = dmem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed testbench for dmem_port_arbiter.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [3:0]  ld_rmask;
    logic        ld_ready;
    logic        ld_resp;
    logic [31:0] ld_rdata;
    logic        st_req;
    logic        st_urgent;
    logic [31:0] st_addr;
    logic [3:0]  st_wmask;
    logic [31:0] st_wdata;
    logic        st_ready;
    logic        st_resp;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        busy;

    int checks = 0;
    int errors = 0;

    dmem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_rmask(ld_rmask),
        .ld_ready(ld_ready), .ld_resp(ld_resp), .ld_rdata(ld_rdata),
        .st_req(st_req), .st_urgent(st_urgent), .st_addr(st_addr),
        .st_wmask(st_wmask), .st_wdata(st_wdata),
        .st_ready(st_ready), .st_resp(st_resp),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0;
        ld_req = 1'b1; ld_addr = 32'h0; ld_rmask = 4'hF;
        st_req = 1'b0; st_urgent = 1'b0; st_addr = 32'h0; st_wmask = 4'h0; st_wdata = 32'h0;
        dmem_rdata = 32'h0; dmem_resp = 1'b0;
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready: got %b expected 0", ld_ready); end
        checks++; if (dmem_rmask !== 4'h0 || dmem_wmask !== 4'h0) begin errors++;
            $display("FAIL reset_masks: got r=%h w=%h expected 0/0", dmem_rmask, dmem_wmask); end
        checks++; if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin errors++;
            $display("FAIL reset_addr_wdata: got %h/%h expected 0/0", dmem_addr, dmem_wdata); end
        ld_req = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || st_ready !== 1'b0) begin errors++;
            $display("FAIL post_reset_idle: got busy=%b st_ready=%b expected 0/0", busy, st_ready); end
    endtask

    task automatic test_lone_load();
        tick();
        ld_req = 1'b1; ld_addr = 32'h1000; ld_rmask = 4'hF; #1;
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL lone_ld_ready: got %b expected 1", ld_ready); end
        tick(); ld_req = 1'b0; #1;
        checks++; if (dmem_rmask !== 4'hF || dmem_addr !== 32'h1000 || dmem_wmask !== 4'h0) begin errors++;
            $display("FAIL lone_ld_bus: got addr=%h r=%h w=%h expected 1000/f/0", dmem_addr, dmem_rmask, dmem_wmask); end
        checks++; if (busy !== 1'b1 || ld_ready !== 1'b0) begin errors++;
            $display("FAIL lone_ld_busy: got busy=%b ready=%b expected 1/0", busy, ld_ready); end
        tick();
        checks++; if (ld_resp !== 1'b0) begin errors++; $display("FAIL lone_ld_early_resp: got %b expected 0", ld_resp); end
        tick(); dmem_resp = 1'b1; dmem_rdata = 32'hDEADBEEF; #1;
        checks++; if (ld_resp !== 1'b1 || ld_rdata !== 32'hDEADBEEF) begin errors++;
            $display("FAIL lone_ld_resp: got resp=%b data=%h expected 1/deadbeef", ld_resp, ld_rdata); end
        checks++; if (st_resp !== 1'b0) begin errors++; $display("FAIL lone_ld_st_resp: got %b expected 0", st_resp); end
        tick(); dmem_resp = 1'b0; dmem_rdata = 32'h0; #1;
        checks++; if (busy !== 1'b0 || dmem_rmask !== 4'h0) begin errors++;
            $display("FAIL lone_ld_done: got busy=%b rmask=%h expected 0/0", busy, dmem_rmask); end
    endtask

    task automatic test_ld_st_simul();
        ld_req = 1'b1; ld_addr = 32'h1004; ld_rmask = 4'h3;
        st_req = 1'b1; st_addr = 32'h3000; st_wmask = 4'hF; st_wdata = 32'h12345678; #1;
        checks++; if (ld_ready !== 1'b1 || st_ready !== 1'b0) begin errors++;
            $display("FAIL simul_first: got ld=%b st=%b expected 1/0", ld_ready, st_ready); end
        tick(); ld_req = 1'b0; #1;
        checks++; if (dmem_wmask !== 4'h0 || dmem_rmask !== 4'h3 || st_ready !== 1'b0) begin errors++;
            $display("FAIL simul_ld_phase: got w=%h r=%h st_ready=%b expected 0/3/0", dmem_wmask, dmem_rmask, st_ready); end
        dmem_resp = 1'b1; #1;
        checks++; if (ld_resp !== 1'b1) begin errors++; $display("FAIL simul_ld_resp: got %b expected 1", ld_resp); end
        tick(); dmem_resp = 1'b0; #1;
        checks++; if (st_ready !== 1'b1 || ld_ready !== 1'b0) begin errors++;
            $display("FAIL simul_second: got st=%b ld=%b expected 1/0", st_ready, ld_ready); end
        tick(); st_req = 1'b0; #1;
        checks++; if (dmem_wmask !== 4'hF || dmem_wdata !== 32'h12345678 || dmem_addr !== 32'h3000 || dmem_rmask !== 4'h0) begin errors++;
            $display("FAIL simul_st_bus: got addr=%h w=%h d=%h r=%h expected 3000/f/12345678/0", dmem_addr, dmem_wmask, dmem_wdata, dmem_rmask); end
        dmem_resp = 1'b1; #1;
        checks++; if (st_resp !== 1'b1 || ld_resp !== 1'b0) begin errors++;
            $display("FAIL simul_st_resp: got st=%b ld=%b expected 1/0", st_resp, ld_resp); end
        tick(); dmem_resp = 1'b0; #1;
        checks++; if (dmem_wmask !== 4'h0 || busy !== 1'b0) begin errors++;
            $display("FAIL simul_done: got w=%h busy=%b expected 0/0", dmem_wmask, busy); end
    endtask

    task automatic test_urgent();
        ld_req = 1'b1; ld_addr = 32'h1008; ld_rmask = 4'hF;
        st_req = 1'b1; st_urgent = 1'b1; st_addr = 32'h2000; st_wmask = 4'h3; st_wdata = 32'h0000ABCD; #1;
        checks++; if (st_ready !== 1'b1 || ld_ready !== 1'b0) begin errors++;
            $display("FAIL urgent_ready: got st=%b ld=%b expected 1/0", st_ready, ld_ready); end
        tick(); st_req = 1'b0; st_urgent = 1'b0; #1;
        checks++; if (dmem_addr !== 32'h2000 || dmem_wmask !== 4'h3 || dmem_wdata !== 32'h0000ABCD || dmem_rmask !== 4'h0) begin errors++;
            $display("FAIL urgent_bus: got addr=%h w=%h d=%h r=%h expected 2000/3/0000abcd/0", dmem_addr, dmem_wmask, dmem_wdata, dmem_rmask); end
        tick();
        checks++; if (dmem_addr !== 32'h2000 || dmem_wmask !== 4'h3 || ld_ready !== 1'b0) begin errors++;
            $display("FAIL urgent_hold: got addr=%h w=%h ld_ready=%b expected 2000/3/0", dmem_addr, dmem_wmask, ld_ready); end
        dmem_resp = 1'b1; #1;
        checks++; if (st_resp !== 1'b1) begin errors++; $display("FAIL urgent_st_resp: got %b expected 1", st_resp); end
        tick(); dmem_resp = 1'b0; #1;
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL urgent_then_ld: got %b expected 1", ld_ready); end
        tick(); ld_req = 1'b0; dmem_resp = 1'b1; #1;
        tick(); dmem_resp = 1'b0; #1;
    endtask

    task automatic test_flush();
        ld_req = 1'b1; ld_addr = 32'h1010; ld_rmask = 4'hF; #1;
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL flush_ld_ready: got %b expected 1", ld_ready); end
        tick(); ld_req = 1'b0; flush = 1'b1; #1;
        tick(); flush = 1'b0; #1;
        tick(); dmem_resp = 1'b1; dmem_rdata = 32'h00000055; #1;
        checks++; if (ld_resp !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL flush_squash: got resp=%b busy=%b expected 0/1", ld_resp, busy); end
        tick(); dmem_resp = 1'b0; dmem_rdata = 32'h0; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle: got busy=%b expected 0", busy); end
        ld_req = 1'b1; ld_addr = 32'h1014; #1;
        tick(); ld_req = 1'b0; dmem_resp = 1'b1; dmem_rdata = 32'hCAFEF00D; #1;
        checks++; if (ld_resp !== 1'b1 || ld_rdata !== 32'hCAFEF00D) begin errors++;
            $display("FAIL flush_next_ld: got resp=%b data=%h expected 1/cafef00d", ld_resp, ld_rdata); end
        tick(); dmem_resp = 1'b0; dmem_rdata = 32'h0;
        // Flush in IDLE blocks the load but lets the store through.
        ld_req = 1'b1; st_req = 1'b1; st_addr = 32'h2004; st_wmask = 4'h1; st_wdata = 32'h77; flush = 1'b1; #1;
        checks++; if (ld_ready !== 1'b0 || st_ready !== 1'b1) begin errors++;
            $display("FAIL flush_idle_grant: got ld=%b st=%b expected 0/1", ld_ready, st_ready); end
        tick(); ld_req = 1'b0; st_req = 1'b0; flush = 1'b1; dmem_resp = 1'b1; #1;
        checks++; if (st_resp !== 1'b1) begin errors++; $display("FAIL flush_st_resp: got %b expected 1", st_resp); end
        tick(); flush = 1'b0; dmem_resp = 1'b0; #1;
    endtask

    task automatic test_back_to_back_starve();
        logic exp_st;
        ld_req = 1'b1; ld_addr = 32'h1100; ld_rmask = 4'hF;
        st_req = 1'b1; st_addr = 32'h3100; st_wmask = 4'hF; st_wdata = 32'hA5A5A5A5; #1;
        for (int g = 0; g < 6; g++) begin
`ifdef DMEM_ARB_STARVE_EN
            exp_st = (g == 4);
`else
            exp_st = 1'b0;
`endif
            checks++; if (ld_ready !== !exp_st || st_ready !== exp_st) begin errors++;
                $display("FAIL starve_grant%0d: got ld=%b st=%b expected %b/%b", g, ld_ready, st_ready, !exp_st, exp_st); end
            tick(); dmem_resp = 1'b1; #1;
            checks++; if ((exp_st ? st_resp : ld_resp) !== 1'b1) begin errors++;
                $display("FAIL starve_resp%0d: got ld=%b st=%b expected owner resp", g, ld_resp, st_resp); end
            tick(); dmem_resp = 1'b0; #1;
        end
        ld_req = 1'b0; st_req = 1'b0; #1;
    endtask

    task automatic test_reset_mid_store();
        st_req = 1'b1; st_addr = 32'h4000; st_wmask = 4'hF; st_wdata = 32'h11; #1;
        checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", st_ready); end
        tick(); st_req = 1'b0; #1;
        checks++; if (busy !== 1'b1 || dmem_wmask !== 4'hF) begin errors++;
            $display("FAIL rstmid_busy: got busy=%b w=%h expected 1/f", busy, dmem_wmask); end
        #1 rst = 1'b0; #1;
        checks++; if (busy !== 1'b0 || dmem_wmask !== 4'h0 || dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin errors++;
            $display("FAIL rstmid_clear: got busy=%b w=%h addr=%h d=%h expected 0/0/0/0", busy, dmem_wmask, dmem_addr, dmem_wdata); end
        checks++; if (st_resp !== 1'b0 || ld_ready !== 1'b0 || st_ready !== 1'b0 || ld_rdata !== 32'h0) begin errors++;
            $display("FAIL rstmid_outs: got st_resp=%b ldr=%b str=%b rd=%h expected 0", st_resp, ld_ready, st_ready, ld_rdata); end
        tick(); rst = 1'b1; dmem_resp = 1'b1; #1;
        checks++; if (st_resp !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL rstmid_stray_resp: got st_resp=%b busy=%b expected 0/0", st_resp, busy); end
        tick(); dmem_resp = 1'b0; #1;
        checks++; if (busy !== 1'b0 || dmem_rmask !== 4'h0) begin errors++;
            $display("FAIL rstmid_final: got busy=%b r=%h expected 0/0", busy, dmem_rmask); end
    endtask

    initial begin
        test_reset();
        test_lone_load();
        test_ld_st_simul();
        test_urgent();
        test_flush();
        test_back_to_back_starve();
        test_reset_mid_store();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
